// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the IF-stage, MEM-stage and memory-command signals of mem_port_arbiter.
// Ports   : IF_* fetch request/response, MEM_* load/store request/response,
//           Mem_* single-ported memory command/read data, Arb_Busy status.
// Modports: slave = arbiter side, master = pipeline + memory side (testbench / integration).
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Fetch requester
  logic                  IF_Request;
  logic [ADDR_WIDTH-1:0] IF_Address;
  logic [DATA_WIDTH-1:0] IF_ReadData;
  logic                  IF_Ready;
  // Load/store requester
  logic                  MEM_Request;
  logic                  MEM_Write;
  logic [ADDR_WIDTH-1:0] MEM_Address;
  logic [DATA_WIDTH-1:0] MEM_WriteData;
  logic [DATA_WIDTH-1:0] MEM_ReadData;
  logic                  MEM_Ready;
  // Memory command side
  logic                  Mem_Enable;
  logic                  Mem_Write;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_WriteData;
  logic [DATA_WIDTH-1:0] Mem_ReadData;
  // Status
  logic                  Arb_Busy;

  modport slave (
    input  IF_Request, IF_Address, MEM_Request, MEM_Write, MEM_Address, MEM_WriteData,
           Mem_ReadData,
    output IF_ReadData, IF_Ready, MEM_ReadData, MEM_Ready,
           Mem_Enable, Mem_Write, Mem_Address, Mem_WriteData, Arb_Busy
  );

  modport master (
    output IF_Request, IF_Address, MEM_Request, MEM_Write, MEM_Address, MEM_WriteData,
           Mem_ReadData,
    input  IF_ReadData, IF_Ready, MEM_ReadData, MEM_Ready,
           Mem_Enable, Mem_Write, Mem_Address, Mem_WriteData, Arb_Busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported fixed-latency memory between IF (fetch) and MEM (load/store);
//           MEM wins ties. Optional perf counters with `define MEM_PORT_ARBITER_PERF_EN.
// Latency : request seen in IDLE at t -> Mem_Enable at t+1 -> x_Ready at t+2+MEM_LATENCY.
// Backpres: requesters hold Request until their one-cycle Ready; absence of Ready stalls the pipe.
// Ports   : CLK, Reset (async active-low), bus (mem_port_arbiter_if.slave),
//           [perf] IF_StallCount, MEM_StallCount, ConflictCount.
// MEM_LATENCY must be >= 1.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]       IF_StallCount,
  output logic [31:0]       MEM_StallCount,
  output logic [15:0]       ConflictCount
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_IF,
    WAIT_IF,
    DONE_IF,
    GRANT_MEM,
    WAIT_MEM,
    DONE_MEM
  } arbState_t;

  arbState_t             state;
  arbState_t             nextState;
  logic [CNT_W-1:0]      waitCount;
  logic                  lastWait;

  logic                  memEnable;
  logic                  ifReady;
  logic                  memReady;
  logic                  busy;

  logic                  cmdWrite;
  logic [ADDR_WIDTH-1:0] cmdAddress;
  logic [DATA_WIDTH-1:0] cmdWriteData;
  logic [DATA_WIDTH-1:0] ifReadData;
  logic [DATA_WIDTH-1:0] memReadData;

  // Count of 1 marks the cycle in which Mem_ReadData is valid.
  assign lastWait = (waitCount == CNT_W'(1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    memEnable = 1'b0;
    ifReady   = 1'b0;
    memReady  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // MEM holds the older instruction, so it wins a tie.
        if (bus.MEM_Request) begin
          nextState = GRANT_MEM;
        end else if (bus.IF_Request) begin
          nextState = GRANT_IF;
        end
      end
      GRANT_IF: begin
        memEnable = 1'b1;
        nextState = WAIT_IF;
      end
      WAIT_IF: begin
        if (lastWait) begin
          nextState = DONE_IF;
        end
      end
      DONE_IF: begin
        ifReady   = 1'b1;
        nextState = IDLE;
      end
      GRANT_MEM: begin
        memEnable = 1'b1;
        nextState = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (lastWait) begin
          nextState = DONE_MEM;
        end
      end
      DONE_MEM: begin
        memReady  = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Command registers are loaded only on the IDLE->GRANT edge and then held
  // through WAIT, so the memory sees a stable command for the whole access.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      waitCount    <= '0;
      cmdWrite     <= 1'b0;
      cmdAddress   <= '0;
      cmdWriteData <= '0;
      ifReadData   <= '0;
      memReadData  <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.MEM_Request) begin
          cmdWrite     <= bus.MEM_Write;
          cmdAddress   <= bus.MEM_Address;
          cmdWriteData <= bus.MEM_WriteData;
        end else if (bus.IF_Request) begin
          cmdWrite     <= 1'b0;
          cmdAddress   <= bus.IF_Address;
          cmdWriteData <= '0;
        end
      end

      case (state)
        GRANT_IF, GRANT_MEM: waitCount <= CNT_W'(MEM_LATENCY);
        WAIT_IF, WAIT_MEM:   waitCount <= waitCount - CNT_W'(1);
        default:             waitCount <= waitCount;
      endcase

      // Stores capture too; the value is simply meaningless for them.
      if (state == WAIT_IF && lastWait) begin
        ifReadData <= bus.Mem_ReadData;
      end
      if (state == WAIT_MEM && lastWait) begin
        memReadData <= bus.Mem_ReadData;
      end
    end
  end

  assign bus.Mem_Enable    = memEnable;
  assign bus.Mem_Write     = cmdWrite;
  assign bus.Mem_Address   = cmdAddress;
  assign bus.Mem_WriteData = cmdWriteData;
  assign bus.IF_Ready      = ifReady;
  assign bus.MEM_Ready     = memReady;
  assign bus.IF_ReadData   = ifReadData;
  assign bus.MEM_ReadData  = memReadData;
  assign bus.Arb_Busy      = busy;

`ifdef MEM_PORT_ARBITER_PERF_EN
  // Saturating stall/conflict counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      IF_StallCount  <= '0;
      MEM_StallCount <= '0;
      ConflictCount  <= '0;
    end else begin
      if (bus.IF_Request && !ifReady && (IF_StallCount != '1)) begin
        IF_StallCount <= IF_StallCount + 32'd1;
      end
      if (bus.MEM_Request && !memReady && (MEM_StallCount != '1)) begin
        MEM_StallCount <= MEM_StallCount + 32'd1;
      end
      if (state == IDLE && bus.IF_Request && bus.MEM_Request && (ConflictCount != '1)) begin
        ConflictCount <= ConflictCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Grants one transaction at a time and sequences the memory command.
- Returns read data and a one-cycle Ready pulse to the winning requester.
- The pipeline uses the absence of Ready to hold PC and the pipeline registers, in the same way it already stalls on load-use hazards.

Parameters:
- DATA_WIDTH, 32, width of data buses.
- ADDR_WIDTH, 32, width of address buses.
- MEM_LATENCY, 2, cycles from the command cycle to valid Mem_ReadData. Must be >= 1; 0 is illegal.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IF_Request  input  1  fetch access wanted; held until IF_Ready.
- IF_Address  input  ADDR_WIDTH  fetch address; stable while IF_Request is high.
- IF_ReadData  output  DATA_WIDTH  fetched instruction; valid when IF_Ready is high.
- IF_Ready  output  1  one-cycle completion pulse for IF.
- MEM_Request  input  1  data access wanted; held until MEM_Ready.
- MEM_Write  input  1  1 = store, 0 = load.
- MEM_Address  input  ADDR_WIDTH  data address.
- MEM_WriteData  input  DATA_WIDTH  store data.
- MEM_ReadData  output  DATA_WIDTH  load data; valid when MEM_Ready is high.
- MEM_Ready  output  1  one-cycle completion pulse for MEM.
- Mem_Enable  output  1  one-cycle command strobe to memory.
- Mem_Write  output  1  command type.
- Mem_Address  output  ADDR_WIDTH  command address.
- Mem_WriteData  output  DATA_WIDTH  command store data.
- Mem_ReadData  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the Mem_Enable cycle.
- Arb_Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE, counter = 0.
  - All outputs = 0, including the data and address registers.
  - Any in-flight transaction is abandoned; memory data arriving after reset is ignored and no Ready is issued for it.
- States:
  - IDLE: requests are sampled here only.
    - MEM_Request = 1 → GRANT_MEM.
    - Else IF_Request = 1 → GRANT_IF.
    - Else stay in IDLE.
    - When both request, MEM wins (it holds the older instruction).
  - GRANT_x (1 cycle):
    - Mem_Enable = 1.
    - Mem_Write = MEM_Write for MEM, 0 for IF.
    - Mem_Address and Mem_WriteData are registered copies of the winner's inputs, captured on the IDLE→GRANT edge.
    - Counter loaded with MEM_LATENCY; go to WAIT_x.
  - WAIT_x:
    - Counter decrements each cycle.
    - Mem_Address, Mem_WriteData and Mem_Write are held stable; Mem_Enable = 0.
    - When counter = 1 (the cycle in which Mem_ReadData is valid), capture Mem_ReadData into x_ReadData and go to DONE_x.
    - Stores capture as well; the captured data is don't-care.
  - DONE_x (1 cycle):
    - x_Ready = 1; the other Ready stays 0.
    - Requests are not sampled.
    - Next state is IDLE.
- Latency: request first seen in IDLE at cycle t → Mem_Enable at t+1 → Ready at t+2+MEM_LATENCY.
  - Minimum spacing between commands is MEM_LATENCY+3 cycles.
- Ready rules:
  - Never both Ready outputs high in the same cycle.
  - Each Ready is exactly one cycle long.
  - x_ReadData holds its value until the next capture for the same requester.
- A request still high in the cycle after DONE is treated as a new transaction.
  - A requester wanting only one access must drop its request on or before the cycle after Ready.
- A request dropped mid-transaction does not cancel it; Ready is still pulsed.
- Arb_Busy = 1 in every state except IDLE.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- When defined, three extra outputs are present:
  - IF_StallCount (32 bits): increments every cycle in which IF_Request = 1 and IF_Ready = 0.
  - MEM_StallCount (32 bits): same rule for MEM.
  - ConflictCount (16 bits): increments in each IDLE cycle where both requests are high.
  - All three saturate at all-ones and reset to 0.
- When not defined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- MEM_LATENCY = 2, IF_Request held with IF_Address = 0x00000040, memory returns 0x8C220004:
  - Mem_Enable at cycle 1, IF_Ready at cycle 4, IF_ReadData = 0x8C220004, MEM_Ready stays 0.
- Both requests at cycle 0, MEM_Write = 1, MEM_Address = 0x100, MEM_WriteData = 0xDEADBEEF:
  - MEM is granted first; Mem_Write = 1 with address and data held through WAIT.
  - MEM_Ready at cycle 4; IF Mem_Enable at cycle 6; IF_Ready at cycle 9.
- IF_Request held continuously for 3 fetches:
  - Mem_Enable at cycles 1, 6, 11; IF_Ready at cycles 4, 9, 14.
- Reset pulled low during WAIT_IF, released 2 cycles later:
  - Immediate IDLE, all outputs 0, no IF_Ready for the abandoned fetch.
  - Next request served with normal latency.
- MEM_LATENCY = 1, MEM load from 0x200 returning 0x12345678:
  - MEM_Ready at cycle 3, MEM_ReadData = 0x12345678, Arb_Busy high in cycles 1–3.
- With MEM_PORT_ARBITER_PERF_EN, scenario 2 repeated:
  - ConflictCount = 1, MEM_StallCount = 4, IF_StallCount = 9.
